bcd_field_setter: RTL
=====================

// Module: bcd_field_setter
// PURPOSE
//  Parametrised settings FSM for N BCD fields (HH:MM:SS, alarm, date). Snapshots the running value on
//  entry, edits one field at a time with inc/dec wrap inside per-field [MIN,MAX], then commits or cancels.
//  Sits between the key debouncers and the clock/alarm counters; drives the display blink selector.
// PARAMETERS
//  NF            3                        number of 8-bit BCD fields; field 0 is edited first
//  FIELD_MAX     {8'h59,8'h59,8'h23}      packed NF*8; field i max at [8*i+:8]
//  FIELD_MIN     {8'h00,8'h00,8'h00}      packed NF*8; field i min (e.g. 8'h01 for day/month)
//  RESET_VAL     {8'h00,8'h12,8'h16}      packed NF*8; set_val after reset
//  TIMEOUT_TICKS 10                       tick_p pulses of inactivity before cancel; 0 = never
//  REPEAT_DLY    24'd500_000              cycles of hold before first auto-repeat (macro only)
//  REPEAT_RATE   24'd100_000              cycles between auto-repeats (macro only)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      synchronous reset, active low
//  set_p      in   1      set key pulse: enter edit / commit
//  sel_p      in   1      select key pulse: next field
//  inc_p      in   1      increment pulse
//  dec_p      in   1      decrement pulse
//  inc_hold   in   1      inc key level (auto-repeat)
//  dec_hold   in   1      dec key level (auto-repeat)
//  tick_p     in   1      timebase pulse for inactivity timeout
//  cur_val    in   NF*8   live value from counter, snapshotted on entry
//  set_en     out  1      high in EDIT and COMMIT; counter halts
//  set_load   out  1      one-cycle commit pulse
//  set_val    out  NF*8   edited value; valid while set_load high
//  field_sel  out  $clog2(NF+1)  field under edit; NF = none (no blink)
//  cancel_p   out  1      one-cycle pulse on timeout exit
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, set_val=RESET_VAL, field_sel=NF, set_en=0, set_load=0,
//   cancel_p=0, timeout/repeat counters 0. Reset mid-edit discards edits, no set_load.
//  States: IDLE -> EDIT on set_p; EDIT -> COMMIT on set_p; COMMIT -> IDLE unconditionally (1 cycle);
//   EDIT -> IDLE on timeout. All outputs registered.
//  Entry: cycle after set_p in IDLE, set_val=cur_val (sanitised), field_sel=0, set_en=1. Sanitise:
//   a field with nibble>9, or <MIN, or >MAX loads as MIN.
//  EDIT priority per cycle: set_p > sel_p > inc/dec. sel_p: field_sel=(field_sel==NF-1)?0:field_sel+1.
//  inc_p alone: field += 1 in BCD; at MAX wraps to MIN. dec_p alone: -1 BCD; at MIN wraps to MAX.
//   inc_p&dec_p same cycle: no change. Carry 9->0 bumps tens nibble; no cross-field carry.
//  COMMIT: set_load=1, set_en=1, field_sel=NF; next cycle IDLE, set_en=0. Latency set_p->set_load: 1 cycle.
//  Timeout: counter clears on any key pulse or EDIT entry; increments on tick_p in EDIT; on reaching
//   TIMEOUT_TICKS -> IDLE, cancel_p=1 one cycle, no set_load, set_val retains edited value.
//  Keys in IDLE other than set_p ignored; keys in COMMIT ignored.
// CONFIGURATION
//  BCD_FIELD_SETTER_REPEAT_EN defined: in EDIT, inc_hold (xor dec_hold) held continuously REPEAT_DLY
//   cycles generates an internal step, then every REPEAT_RATE cycles; release, both held, or field
//   change resets the repeat counter; repeat steps also clear the timeout counter.
//  Not defined: hold inputs ignored, repeat counter and REPEAT_* unused; only pulses step.
// STRUCTURE
//  Package clock_pkg: setter state enum (IDLE/EDIT/COMMIT), BCD_W=8, functions bcd_valid, bcd_inc, bcd_dec.
//  Sub-module bcd_field_step (combinational): val,min,max,inc,dec -> next val with wrap; one instance
//   on the selected field via field_sel mux, write-back to that slice only.
// TESTING
//  1 cur_val=24'h59_59_23, set_p, inc_p -> field0 = 8'h00, set_p -> set_load 1 cycle, set_val=24'h59_59_00.
//  2 field0=8'h00, dec_p -> 8'h23; sel_p x3 -> field_sel 1,2,0; field1 8'h09 inc -> 8'h10.
//  3 FIELD_MIN field1=8'h01, cur field1=8'h00 -> loads 8'h01; dec at 8'h01 -> MAX.
//  4 EDIT, 10 tick_p no keys -> cancel_p pulse, set_en=0, set_load never; key at tick 9 restarts count.
//  5 set_p+sel_p+inc_p same cycle in EDIT -> COMMIT only; inc_p&dec_p -> no change.
//  6 rst_n low mid-EDIT -> next cycle IDLE, set_val=RESET_VAL, field_sel=NF; with REPEAT_EN, hold inc
//    REPEAT_DLY+2*REPEAT_RATE cycles -> exactly 3 steps.

Source files
------------

// File: rtl/bcd_field_setter_pkg.sv
// ============================================================================
//  Module   : clock_pkg
//  Brief    : Setter state encoding and packed-BCD field helpers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int BCD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } setter_state_e;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_field_setter_step.sv
// ============================================================================
//  Module   : bcd_field_step
//  Brief    : Combinational +/-1 BCD step with wrap inside [min,max].
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_field_step
    import clock_pkg::*;
(
    input  logic [BCD_W-1:0] val,
    input  logic [BCD_W-1:0] min,
    input  logic [BCD_W-1:0] max,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] nxt
);

    // Both keys together cancel out; valid BCD orders the same as binary.
    always_comb begin
        nxt = val;
        if (inc && !dec) begin
            nxt = (val >= max) ? min : bcd_inc(val);
        end else if (dec && !inc) begin
            nxt = (val <= min) ? max : bcd_dec(val);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_field_setter.sv
// ============================================================================
//  Module   : bcd_field_setter
//  Brief    : Snapshot / edit / commit FSM for NF packed BCD fields.
//             Key auto-repeat enabled by defining BCD_FIELD_SETTER_REPEAT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_field_setter
    import clock_pkg::*;
#(
    parameter int              NF            = 3,
    parameter logic [NF*8-1:0] FIELD_MAX     = {8'h59, 8'h59, 8'h23},
    parameter logic [NF*8-1:0] FIELD_MIN     = {8'h00, 8'h00, 8'h00},
    parameter logic [NF*8-1:0] RESET_VAL     = {8'h00, 8'h12, 8'h16},
    parameter int              TIMEOUT_TICKS = 10,
    parameter logic [23:0]     REPEAT_DLY    = 24'd500_000,
    parameter logic [23:0]     REPEAT_RATE   = 24'd100_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_p,
    input  logic                      sel_p,
    input  logic                      inc_p,
    input  logic                      dec_p,
    input  logic                      inc_hold,
    input  logic                      dec_hold,
    input  logic                      tick_p,
    input  logic [NF*8-1:0]           cur_val,
    output logic                      set_en,
    output logic                      set_load,
    output logic [NF*8-1:0]           set_val,
    output logic [$clog2(NF+1)-1:0]   field_sel,
    output logic                      cancel_p
);

    localparam int FSW = $clog2(NF + 1);
    localparam int TW  = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
    localparam logic [FSW-1:0] SEL_NONE = FSW'(NF);
    localparam logic [FSW-1:0] SEL_LAST = FSW'(NF - 1);

    setter_state_e   state_q, state_d;
    logic [NF*8-1:0] set_val_q, set_val_d;
    logic [FSW-1:0]  field_sel_q, field_sel_d;
    logic            set_en_q, set_en_d;
    logic            set_load_q, set_load_d;
    logic            cancel_p_q, cancel_p_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic [NF*8-1:0] entry_val;
    logic [7:0]      sel_val, sel_min, sel_max, step_val;
    logic            step_inc, step_dec;

    // Snapshot sanitising: any malformed or out-of-range field loads as its MIN.
    for (genvar i = 0; i < NF; i++) begin : g_field
        localparam logic [7:0] MN = FIELD_MIN[8*i +: 8];
        localparam logic [7:0] MX = FIELD_MAX[8*i +: 8];
        logic [7:0] f;
        assign f = cur_val[8*i +: 8];
        assign entry_val[8*i +: 8] = (!bcd_valid(f) || (f < MN) || (f > MX)) ? MN : f;
    end

    always_comb begin
        sel_val = '0;
        sel_min = '0;
        sel_max = '0;
        for (int i = 0; i < NF; i++) begin
            if (field_sel_q == FSW'(i)) begin
                sel_val = set_val_q[8*i +: 8];
                sel_min = FIELD_MIN[8*i +: 8];
                sel_max = FIELD_MAX[8*i +: 8];
            end
        end
    end

    bcd_field_step u_step (
        .val (sel_val),
        .min (sel_min),
        .max (sel_max),
        .inc (step_inc),
        .dec (step_dec),
        .nxt (step_val)
    );

`ifdef BCD_FIELD_SETTER_REPEAT_EN
    logic [23:0] rep_cnt_q, rep_cnt_d;
    logic        rep_armed_q, rep_armed_d;
    logic        rep_step;

    // First step after REPEAT_DLY held cycles, then one per REPEAT_RATE.
    always_comb begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
        rep_step    = 1'b0;
        if ((state_q == ST_EDIT) && (inc_hold ^ dec_hold) && !sel_p && !set_p) begin
            if ((rep_cnt_q + 24'd1) >= (rep_armed_q ? REPEAT_RATE : REPEAT_DLY)) begin
                rep_step    = 1'b1;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d   = rep_cnt_q + 24'd1;
                rep_armed_d = rep_armed_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    assign step_inc = inc_p | (rep_step & inc_hold);
    assign step_dec = dec_p | (rep_step & dec_hold);
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, inc_hold, dec_hold, REPEAT_DLY, REPEAT_RATE};
    assign step_inc  = inc_p;
    assign step_dec  = dec_p;
`endif

    always_comb begin
        state_d     = state_q;
        set_val_d   = set_val_q;
        field_sel_d = field_sel_q;
        set_en_d    = 1'b0;
        set_load_d  = 1'b0;
        cancel_p_d  = 1'b0;
        tmo_d       = tmo_q;
        case (state_q)
            ST_IDLE: begin
                field_sel_d = SEL_NONE;
                tmo_d       = '0;
                if (set_p) begin
                    state_d     = ST_EDIT;
                    set_val_d   = entry_val;
                    field_sel_d = '0;
                    set_en_d    = 1'b1;
                end
            end
            ST_EDIT: begin
                set_en_d = 1'b1;
                if (set_p) begin
                    state_d     = ST_COMMIT;
                    set_load_d  = 1'b1;
                    field_sel_d = SEL_NONE;
                    tmo_d       = '0;
                end else if (sel_p) begin
                    field_sel_d = (field_sel_q == SEL_LAST) ? '0 : field_sel_q + FSW'(1);
                    tmo_d       = '0;
                end else if (step_inc || step_dec) begin
                    for (int i = 0; i < NF; i++) begin
                        if (field_sel_q == FSW'(i)) set_val_d[8*i +: 8] = step_val;
                    end
                    tmo_d = '0;
                end else if (tick_p && (TIMEOUT_TICKS != 0)) begin
                    if (tmo_q == TW'(TIMEOUT_TICKS - 1)) begin
                        state_d     = ST_IDLE;
                        set_en_d    = 1'b0;
                        cancel_p_d  = 1'b1;
                        field_sel_d = SEL_NONE;
                        tmo_d       = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            ST_COMMIT: begin
                state_d     = ST_IDLE;
                field_sel_d = SEL_NONE;
                tmo_d       = '0;
            end
            default: begin
                state_d     = ST_IDLE;
                field_sel_d = SEL_NONE;
                tmo_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            set_val_q   <= RESET_VAL;
            field_sel_q <= SEL_NONE;
            set_en_q    <= 1'b0;
            set_load_q  <= 1'b0;
            cancel_p_q  <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            set_val_q   <= set_val_d;
            field_sel_q <= field_sel_d;
            set_en_q    <= set_en_d;
            set_load_q  <= set_load_d;
            cancel_p_q  <= cancel_p_d;
            tmo_q       <= tmo_d;
        end
    end

    assign set_en    = set_en_q;
    assign set_load  = set_load_q;
    assign set_val   = set_val_q;
    assign field_sel = field_sel_q;
    assign cancel_p  = cancel_p_q;

endmodule

`default_nettype wire
